alu_issue_sched: RTL and testbench

Reservation-station scheduler for the ALU execution unit in the out-of-order RISC-V core. Holds up to `RS_SIZE` decoded ALU/branch/jump instructions, captures operand values from the common data bus (CDB), picks one ready entry per cycle with rotating priority, and drives the operand register feeding the combinational EX unit. It latches the EX result with its ROB tag in an output register that holds under CDB backpressure.

---
 rtl/alu_issue_sched.sv | 252 +++++++++++++++++++++++++
 tb/tb_alu_issue_sched.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_sched.sv
// ALU reservation station: CDB wakeup, rotating-priority issue into the EX operand
// register (stage D), and a result register that holds under CDB backpressure.
module alu_issue_sched #(
    parameter int RS_SIZE = 8,
    parameter int TAG_W   = 4,
    parameter int TYPE_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [TYPE_W-1:0] alloc_type,
    input  logic              alloc_qj_busy,
    input  logic              alloc_qk_busy,
    input  logic [TAG_W-1:0]  alloc_qj,
    input  logic [TAG_W-1:0]  alloc_qk,
    input  logic [31:0]       alloc_vj,
    input  logic [31:0]       alloc_vk,
    input  logic [31:0]       alloc_a,
    input  logic [31:0]       alloc_pc,
    input  logic [TAG_W-1:0]  alloc_dest,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [31:0]       cdb_value,
    output logic [TYPE_W-1:0] ex_type,
    output logic [31:0]       ex_vj,
    output logic [31:0]       ex_vk,
    output logic [31:0]       ex_a,
    output logic [31:0]       ex_pc,
    input  logic [31:0]       ex_value,
    input  logic [31:0]       ex_jumppc,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [TAG_W-1:0]  res_tag,
    output logic [31:0]       res_value,
    output logic [31:0]       res_jumppc
);

    localparam int IDX_W = $clog2(RS_SIZE);

    typedef struct packed {
        logic [TYPE_W-1:0] itype;
        logic              qj_busy;
        logic [TAG_W-1:0]  qj;
        logic              qk_busy;
        logic [TAG_W-1:0]  qk;
        logic [31:0]       vj;
        logic [31:0]       vk;
        logic [31:0]       a;
        logic [31:0]       pc;
        logic [TAG_W-1:0]  dest;
    } entry_t;

    typedef struct packed {
        logic [TYPE_W-1:0] itype;
        logic [31:0]       vj;
        logic [31:0]       vk;
        logic [31:0]       a;
        logic [31:0]       pc;
    } ex_ops_t;

    logic [RS_SIZE-1:0] busy_q, busy_d;
    entry_t             rs_q [RS_SIZE];
    entry_t             rs_d [RS_SIZE];
    logic [IDX_W-1:0]   last_sel_q, last_sel_d;
    logic               d_valid_q, d_valid_d;
    logic [TAG_W-1:0]   d_dest_q, d_dest_d;
    ex_ops_t            ex_q, ex_d;
    logic               res_valid_q, res_valid_d;
    logic [TAG_W-1:0]   res_tag_q, res_tag_d;
    logic [31:0]        res_value_q, res_value_d;
    logic [31:0]        res_jumppc_q, res_jumppc_d;

    logic [RS_SIZE-1:0] rdy_vec;
    logic               alloc_found;
    logic [IDX_W-1:0]   alloc_idx;
    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   cand_idx;
    logic               res_load;
    logic               d_load;
    logic               pick;
    logic               do_alloc;
    entry_t             alloc_entry;

    assign res_load = !res_valid_q || res_ready;
    assign d_load   = !d_valid_q || res_load;

    // NOTE: every variable driven from always_comb gets a default at the top of the
    // block; a path that leaves one unassigned would infer a latch.
    always_comb begin
        alloc_found = 1'b0;
        alloc_idx   = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            rdy_vec[i] = busy_q[i] && !rs_q[i].qj_busy && !rs_q[i].qk_busy;
            if (!busy_q[i] && !alloc_found) begin
                alloc_found = 1'b1;
                alloc_idx   = IDX_W'(i);
            end
        end
    end

    assign alloc_ready = alloc_found;
    assign do_alloc    = alloc_valid && alloc_found && !clr;

    // Rotating priority: scan starts just after the last entry picked.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand_idx  = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            cand_idx = last_sel_q + IDX_W'(i + 1);
            if (!sel_found && rdy_vec[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    assign pick = d_load && sel_found && !clr;

    // An operand still pending at allocation can be satisfied by this cycle's broadcast.
    always_comb begin
        alloc_entry.itype   = alloc_type;
        alloc_entry.qj_busy = alloc_qj_busy;
        alloc_entry.qj      = alloc_qj;
        alloc_entry.qk_busy = alloc_qk_busy;
        alloc_entry.qk      = alloc_qk;
        alloc_entry.vj      = alloc_vj;
        alloc_entry.vk      = alloc_vk;
        alloc_entry.a       = alloc_a;
        alloc_entry.pc      = alloc_pc;
        alloc_entry.dest    = alloc_dest;
        if (alloc_qj_busy && cdb_valid && cdb_tag == alloc_qj) begin
            alloc_entry.qj_busy = 1'b0;
            alloc_entry.vj      = cdb_value;
        end
        if (alloc_qk_busy && cdb_valid && cdb_tag == alloc_qk) begin
            alloc_entry.qk_busy = 1'b0;
            alloc_entry.vk      = cdb_value;
        end
    end

    always_comb begin
        busy_d = busy_q;
        rs_d   = rs_q;
        if (clr) begin
            busy_d = '0;
        end else begin
            if (cdb_valid) begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy_q[i] && rs_q[i].qj_busy && rs_q[i].qj == cdb_tag) begin
                        rs_d[i].qj_busy = 1'b0;
                        rs_d[i].vj      = cdb_value;
                    end
                    if (busy_q[i] && rs_q[i].qk_busy && rs_q[i].qk == cdb_tag) begin
                        rs_d[i].qk_busy = 1'b0;
                        rs_d[i].vk      = cdb_value;
                    end
                end
            end
            if (pick) begin
                busy_d[sel_idx] = 1'b0;
            end
            // The allocation target is a free entry, never the one being picked.
            if (do_alloc) begin
                busy_d[alloc_idx] = 1'b1;
                rs_d[alloc_idx]   = alloc_entry;
            end
        end
    end

    always_comb begin
        last_sel_d = pick ? sel_idx : last_sel_q;
        d_valid_d  = d_valid_q;
        d_dest_d   = d_dest_q;
        ex_d       = ex_q;
        if (clr) begin
            d_valid_d = 1'b0;
        end else if (d_load) begin
            d_valid_d = pick;
            if (pick) begin
                d_dest_d    = rs_q[sel_idx].dest;
                ex_d.itype  = rs_q[sel_idx].itype;
                ex_d.vj     = rs_q[sel_idx].vj;
                ex_d.vk     = rs_q[sel_idx].vk;
                ex_d.a      = rs_q[sel_idx].a;
                ex_d.pc     = rs_q[sel_idx].pc;
            end
        end
    end

    always_comb begin
        res_valid_d  = res_valid_q;
        res_tag_d    = res_tag_q;
        res_value_d  = res_value_q;
        res_jumppc_d = res_jumppc_q;
        if (res_load) begin
            res_valid_d  = d_valid_q;
            res_tag_d    = d_dest_q;
            res_value_d  = ex_value;
            res_jumppc_d = ex_jumppc;
        end
        if (clr) begin
            res_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q       <= '0;
            last_sel_q   <= IDX_W'(RS_SIZE - 1);
            d_valid_q    <= 1'b0;
            d_dest_q     <= '0;
            ex_q         <= '0;
            res_valid_q  <= 1'b0;
            res_tag_q    <= '0;
            res_value_q  <= '0;
            res_jumppc_q <= '0;
        end else begin
            busy_q       <= busy_d;
            last_sel_q   <= last_sel_d;
            d_valid_q    <= d_valid_d;
            d_dest_q     <= d_dest_d;
            ex_q         <= ex_d;
            res_valid_q  <= res_valid_d;
            res_tag_q    <= res_tag_d;
            res_value_q  <= res_value_d;
            res_jumppc_q <= res_jumppc_d;
        end
    end

    // NOTE: the entry payload array has no reset; it is only observed while its
    // busy bit is set, and the busy bits are reset.
    always_ff @(posedge clk) begin
        rs_q <= rs_d;
    end

    assign ex_type    = ex_q.itype;
    assign ex_vj      = ex_q.vj;
    assign ex_vk      = ex_q.vk;
    assign ex_a       = ex_q.a;
    assign ex_pc      = ex_q.pc;
    assign res_valid  = res_valid_q;
    assign res_tag    = res_tag_q;
    assign res_value  = res_value_q;
    assign res_jumppc = res_jumppc_q;

endmodule

// File: tb/tb_alu_issue_sched.sv
// Bench for alu_issue_sched: directed latency/bypass/backpressure/flush/reset steps,
// then random traffic checked against a tag-indexed scoreboard and a bench-side EX unit.
module tb_alu_issue_sched;

    localparam int TAG_W  = 4;
    localparam int TYPE_W = 6;
    localparam int NTAG   = 16;

    localparam logic [TYPE_W-1:0] T_ADD  = 6'd0;
    localparam logic [TYPE_W-1:0] T_ADDI = 6'd1;
    localparam logic [TYPE_W-1:0] T_SUB  = 6'd2;
    localparam logic [TYPE_W-1:0] T_BEQ  = 6'd3;
    localparam logic [TYPE_W-1:0] T_JALR = 6'd4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clr;
    logic              alloc_valid;
    logic              alloc_ready;
    logic [TYPE_W-1:0] alloc_type;
    logic              alloc_qj_busy, alloc_qk_busy;
    logic [TAG_W-1:0]  alloc_qj, alloc_qk;
    logic [31:0]       alloc_vj, alloc_vk, alloc_a, alloc_pc;
    logic [TAG_W-1:0]  alloc_dest;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [31:0]       cdb_value;
    logic [TYPE_W-1:0] ex_type;
    logic [31:0]       ex_vj, ex_vk, ex_a, ex_pc;
    logic [31:0]       ex_value, ex_jumppc;
    logic              res_valid;
    logic              res_ready;
    logic [TAG_W-1:0]  res_tag;
    logic [31:0]       res_value, res_jumppc;

    int checks = 0;
    int errors = 0;

    // Scoreboard: in-flight instructions indexed by destination tag.
    bit          m_valid [NTAG];
    logic [5:0]  m_type  [NTAG];
    logic [31:0] m_vj [NTAG], m_vk [NTAG], m_a [NTAG], m_pc [NTAG];
    bit          m_qjb [NTAG], m_qkb [NTAG];
    logic [3:0]  m_qj [NTAG], m_qk [NTAG];
    logic [3:0]  pend_q [$];

    int exp_order [10] = '{0, 1, 4, 5, 6, 7, 8, 9, 2, 3};

    always #5 clk = ~clk;

    alu_issue_sched #(.RS_SIZE(8), .TAG_W(TAG_W), .TYPE_W(TYPE_W)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_type(alloc_type),
        .alloc_qj_busy(alloc_qj_busy), .alloc_qk_busy(alloc_qk_busy),
        .alloc_qj(alloc_qj), .alloc_qk(alloc_qk),
        .alloc_vj(alloc_vj), .alloc_vk(alloc_vk), .alloc_a(alloc_a), .alloc_pc(alloc_pc),
        .alloc_dest(alloc_dest),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .ex_type(ex_type), .ex_vj(ex_vj), .ex_vk(ex_vk), .ex_a(ex_a), .ex_pc(ex_pc),
        .ex_value(ex_value), .ex_jumppc(ex_jumppc),
        .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag),
        .res_value(res_value), .res_jumppc(res_jumppc)
    );

    // Bench EX unit: {value, jumppc}.
    function automatic logic [63:0] ex_fn(input logic [TYPE_W-1:0] t, input logic [31:0] vj,
                                          input logic [31:0] vk, input logic [31:0] a,
                                          input logic [31:0] pc);
        case (t)
            T_ADD:   return {vj + vk, 32'd0};
            T_ADDI:  return {vj + a, 32'd0};
            T_SUB:   return {vj - vk, 32'd0};
            T_BEQ:   return {{31'd0, vj == vk}, pc + a};
            T_JALR:  return {pc + 32'd4, vj + a};
            default: return {vj ^ vk, 32'd0};
        endcase
    endfunction

    always_comb {ex_value, ex_jumppc} = ex_fn(ex_type, ex_vj, ex_vk, ex_a, ex_pc);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        alloc_valid = 1'b0;
        cdb_valid   = 1'b0;
        clr         = 1'b0;
    endtask

    task automatic set_alloc(input logic [5:0] t, input bit qjb, input logic [3:0] qj,
                             input bit qkb, input logic [3:0] qk, input logic [31:0] vj,
                             input logic [31:0] vk, input logic [31:0] a,
                             input logic [31:0] pc, input logic [3:0] dest);
        alloc_valid   = 1'b1;
        alloc_type    = t;
        alloc_qj_busy = qjb;
        alloc_qj      = qj;
        alloc_qk_busy = qkb;
        alloc_qk      = qk;
        alloc_vj      = vj;
        alloc_vk      = vk;
        alloc_a       = a;
        alloc_pc      = pc;
        alloc_dest    = dest;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic model_add();
        int t;
        t = int'(alloc_dest);
        m_valid[t] = 1'b1;
        m_type[t]  = alloc_type;
        m_vj[t]    = alloc_vj;
        m_vk[t]    = alloc_vk;
        m_a[t]     = alloc_a;
        m_pc[t]    = alloc_pc;
        m_qjb[t]   = alloc_qj_busy;
        m_qj[t]    = alloc_qj;
        m_qkb[t]   = alloc_qk_busy;
        m_qk[t]    = alloc_qk;
    endtask

    task automatic model_wake(input logic [3:0] tag, input logic [31:0] val);
        for (int t = 0; t < NTAG; t++) begin
            if (m_valid[t] && m_qjb[t] && m_qj[t] == tag) begin
                m_qjb[t] = 1'b0;
                m_vj[t]  = val;
            end
            if (m_valid[t] && m_qkb[t] && m_qk[t] == tag) begin
                m_qkb[t] = 1'b0;
                m_vk[t]  = val;
            end
        end
    endtask

    task automatic retire_check();
        int t;
        logic [63:0] r;
        t = int'(res_tag);
        check("rand_tag_inflight", {31'd0, m_valid[t]}, 32'd1);
        if (m_valid[t]) begin
            r = ex_fn(m_type[t], m_vj[t], m_vk[t], m_a[t], m_pc[t]);
            check("rand_value", res_value, r[63:32]);
            check("rand_jumppc", res_jumppc, r[31:0]);
            m_valid[t] = 1'b0;
        end
    endtask

    function automatic int in_flight();
        int n = 0;
        for (int t = 0; t < NTAG; t++) n += int'(m_valid[t]);
        return n;
    endfunction

    initial begin
        int n_alloc;
        int free_tag;
        bit qjb, qkb;
        logic [3:0] qj, qk, btag;
        logic [31:0] bval;

        rst_n = 1'b0;
        res_ready = 1'b1;
        alloc_type = '0; alloc_qj_busy = 0; alloc_qk_busy = 0; alloc_qj = '0; alloc_qk = '0;
        alloc_vj = '0; alloc_vk = '0; alloc_a = '0; alloc_pc = '0; alloc_dest = '0;
        cdb_tag = '0; cdb_value = '0;
        idle();
        tick();
        tick();
        check("reset_alloc_ready", alloc_ready, 1);
        check("reset_res_valid", res_valid, 0);
        check("reset_res_value", res_value, 0);
        check("reset_ex_vj", ex_vj, 0);
        rst_n = 1'b1;
        tick();

        // ADDI: allocate in cycle 0, result visible in cycle 3.
        set_alloc(T_ADDI, 0, 0, 0, 0, 32'd5, 32'd0, 32'd7, 32'h40, 4'd3);
        tick(); idle();
        tick();
        check("addi_c2_res_valid", res_valid, 0);
        check("addi_c2_ex_vj", ex_vj, 5);
        tick();
        check("addi_res_valid", res_valid, 1);
        check("addi_res_tag", res_tag, 3);
        check("addi_res_value", res_value, 12);
        tick();
        check("addi_retired", res_valid, 0);

        // ADD waiting on tag 2; broadcast two cycles later.
        set_alloc(T_ADD, 1, 4'd2, 0, 0, 32'hdead, 32'd1, 32'd0, 32'd0, 4'd4);
        tick(); idle();
        tick();
        check("wake_wait_res_valid", res_valid, 0);
        cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_value = 32'h10;
        tick(); idle();
        check("wake_b1_res_valid", res_valid, 0);
        tick();
        check("wake_b2_res_valid", res_valid, 0);
        tick();
        check("wake_res_valid", res_valid, 1);
        check("wake_res_tag", res_tag, 4);
        check("wake_res_value", res_value, 32'h11);
        tick();

        // Same-cycle bypass on qk.
        set_alloc(T_ADD, 0, 0, 1, 4'd5, 32'd3, 32'hbad, 32'd0, 32'd0, 4'd6);
        cdb_valid = 1'b1; cdb_tag = 4'd5; cdb_value = 32'd9;
        tick(); idle();
        tick();
        tick();
        check("bypass_res_valid", res_valid, 1);
        check("bypass_res_tag", res_tag, 6);
        check("bypass_res_value", res_value, 12);
        tick();

        // Fill under backpressure, then release and watch rotating retirement.
        do_reset();
        res_ready = 1'b0;
        n_alloc = 0;
        for (int c = 0; c < 20 && alloc_ready; c++) begin
            set_alloc(T_ADDI, 0, 0, 0, 0, 32'(n_alloc * 3), 32'd0, 32'h100, 32'd0, 4'(n_alloc));
            n_alloc++;
            tick();
        end
        idle();
        check("fill_count", 32'(n_alloc), 10);
        check("fill_alloc_ready", alloc_ready, 0);
        for (int c = 0; c < 3; c++) begin
            check("hold_res_valid", res_valid, 1);
            check("hold_res_tag", res_tag, 0);
            check("hold_res_value", res_value, 32'h100);
            tick();
        end
        res_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            check("drain_res_valid", res_valid, 1);
            check("drain_res_tag", res_tag, 32'(exp_order[k]));
            check("drain_res_value", res_value, 32'(exp_order[k] * 3 + 32'h100));
            tick();
        end
        check("drain_done", res_valid, 0);

        // Flush with three entries busy and a result pending.
        res_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_alloc(T_ADDI, 0, 0, 0, 0, 32'(k), 32'd0, 32'd1, 32'd0, 4'(10 + k));
            tick();
        end
        idle();
        check("clr_pre_res_valid", res_valid, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_res_valid", res_valid, 0);
        check("clr_alloc_ready", alloc_ready, 1);
        res_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            check("clr_no_result", res_valid, 0);
        end

        // Asynchronous reset mid-stream.
        set_alloc(T_ADDI, 0, 0, 0, 0, 32'h55, 32'd0, 32'h22, 32'd0, 4'd7);
        tick();
        set_alloc(T_JALR, 0, 0, 0, 0, 32'h1000, 32'd0, 32'd4, 32'h200, 4'd8);
        tick(); idle();
        tick();
        check("areset_pre_res_valid", res_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("areset_res_valid", res_valid, 0);
        check("areset_res_tag", res_tag, 0);
        check("areset_res_value", res_value, 0);
        check("areset_res_jumppc", res_jumppc, 0);
        check("areset_ex_type", ex_type, 0);
        check("areset_ex_vj", ex_vj, 0);
        check("areset_ex_vk", ex_vk, 0);
        check("areset_ex_a", ex_a, 0);
        check("areset_ex_pc", ex_pc, 0);
        check("areset_alloc_ready", alloc_ready, 1);
        tick();
        rst_n = 1'b1;
        tick();

        // Random traffic against the scoreboard.
        for (int t = 0; t < NTAG; t++) m_valid[t] = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            res_ready = ($urandom_range(0, 3) != 0);
            if (res_valid && res_ready) retire_check();
            alloc_valid = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                free_tag = 0;
                for (int t = NTAG - 1; t >= 0; t--) if (!m_valid[t]) free_tag = t;
                qjb = ($urandom_range(0, 2) == 0);
                qkb = ($urandom_range(0, 2) == 0);
                qj  = 4'($urandom_range(0, 15));
                qk  = 4'($urandom_range(0, 15));
                if (qjb) pend_q.push_back(qj);
                if (qkb) pend_q.push_back(qk);
                set_alloc(6'($urandom_range(0, 5)), qjb, qj, qkb, qk, $urandom, $urandom,
                          $urandom, $urandom, 4'(free_tag));
                if (alloc_ready) model_add();
            end
            cdb_valid = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
                btag = (pend_q.size() > 0) ? pend_q.pop_front() : 4'($urandom_range(0, 15));
                bval = $urandom;
                cdb_valid = 1'b1; cdb_tag = btag; cdb_value = bval;
                model_wake(btag, bval);
            end
            tick();
        end

        // Drain: keep broadcasting so every pending operand resolves.
        idle();
        res_ready = 1'b1;
        for (int cyc = 0; cyc < 400 && in_flight() > 0; cyc++) begin
            if (res_valid) retire_check();
            btag = (pend_q.size() > 0) ? pend_q.pop_front() : 4'(cyc % NTAG);
            bval = $urandom;
            cdb_valid = 1'b1; cdb_tag = btag; cdb_value = bval;
            model_wake(btag, bval);
            tick();
        end
        idle();
        check("rand_all_retired", 32'(in_flight()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
